// File: rtl/mult_hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use stalls, multi-cycle multiply holds, taken-branch flushes.
// Optional saturating performance counters are enabled with the macro HAZ_PERF_CNT_EN.
module mult_hazard_ctrl #(
  parameter int MULT_LAT = 3,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rd,
  input  logic             ex_is_mult,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_hold,
  output logic             mult_done,
  output logic [CNT_W-1:0] cnt_load_use,
  output logic [CNT_W-1:0] cnt_mult_stall,
  output logic [CNT_W-1:0] cnt_flush
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Number of BUSY cycles following the IDLE cycle in which the multiply is first seen.
  localparam logic [3:0] LOAD_VAL = 4'(MULT_LAT - 2);

  state_t     state;
  logic [3:0] cnt;
  logic       load_use;
  logic       hold_c;

  always_comb begin
    load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
               ((id_uses_rs1 && (id_rs1 == id_ex_rd)) ||
                (id_uses_rs2 && (id_rs2 == id_ex_rd)));
    hold_c   = ((state == IDLE) && ex_is_mult) || (state == BUSY);
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the block can infer a latch.
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_hold      = 1'b0;
    mult_done    = 1'b0;
    if (arst_n) begin
      mult_done = (state == DONE);
      if (hold_c) begin
        ex_hold     = 1'b1;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
      end else if (ex_branch_taken) begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (load_use) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      unique case (state)
        IDLE: if (ex_is_mult) begin
          if (LOAD_VAL == 4'd0) begin
            state <= DONE;
          end else begin
            state <= BUSY;
            cnt   <= LOAD_VAL;
          end
        end
        BUSY: if (cnt <= 4'd1) begin
          state <= DONE;
          cnt   <= 4'd0;
        end else begin
          cnt <= cnt - 4'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_load_use   <= '0;
      cnt_mult_stall <= '0;
      cnt_flush      <= '0;
    end else begin
      if (!hold_c && !ex_branch_taken && load_use && (cnt_load_use != CNT_MAX))
        cnt_load_use <= cnt_load_use + 1'b1;
      if (hold_c && (cnt_mult_stall != CNT_MAX))
        cnt_mult_stall <= cnt_mult_stall + 1'b1;
      if (!hold_c && ex_branch_taken && (cnt_flush != CNT_MAX))
        cnt_flush <= cnt_flush + 1'b1;
    end
  end
`else
  assign cnt_load_use   = '0;
  assign cnt_mult_stall = '0;
  assign cnt_flush      = '0;
`endif

endmodule

// File: tb/tb_mult_hazard_ctrl.sv
// Directed self-checking bench for mult_hazard_ctrl (MULT_LAT=3); counter expectations follow HAZ_PERF_CNT_EN.
module tb_mult_hazard_ctrl;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             arst_n;
  logic [4:0]       id_rs1, id_rs2, id_ex_rd;
  logic             id_uses_rs1, id_uses_rs2, id_ex_mem_read, ex_is_mult, ex_branch_taken;
  logic             pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold, mult_done;
  logic [CNT_W-1:0] cnt_load_use, cnt_mult_stall, cnt_flush;

  int checks   = 0;
  int failures = 0;

  mult_hazard_ctrl #(.MULT_LAT(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .arst_n(arst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
    .ex_is_mult(ex_is_mult), .ex_branch_taken(ex_branch_taken),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ex_hold(ex_hold), .mult_done(mult_done),
    .cnt_load_use(cnt_load_use), .cnt_mult_stall(cnt_mult_stall), .cnt_flush(cnt_flush)
  );

  always #5 clk = ~clk;

  // Expected output word: {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold, mult_done}
  localparam logic [5:0] PASS  = 6'b110000;
  localparam logic [5:0] STALL = 6'b000100;
  localparam logic [5:0] HOLD  = 6'b000010;
  localparam logic [5:0] DONEP = 6'b110001;
  localparam logic [5:0] FLUSH = 6'b111100;

  task automatic drive(input logic mem_rd, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic u1, input logic [4:0] rs2, input logic u2,
                       input logic mul, input logic br);
    id_ex_mem_read  = mem_rd;
    id_ex_rd        = rd;
    id_rs1          = rs1;
    id_uses_rs1     = u1;
    id_rs2          = rs2;
    id_uses_rs2     = u2;
    ex_is_mult      = mul;
    ex_branch_taken = br;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Settle combinational outputs mid-cycle, then compare.
  task automatic check_outs(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    #1;
    obs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold, mult_done};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    // Reset asserted with hazard-looking inputs: outputs must still be pass-through.
    arst_n = 1'b0;
    drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
    next_cycle();
    check_outs("reset_passthrough", PASS);
    check_cnt("reset_cnt_lu", cnt_load_use, '0);
    check_cnt("reset_cnt_ms", cnt_mult_stall, '0);
    check_cnt("reset_cnt_fl", cnt_flush, '0);
    idle_inputs();
    arst_n = 1'b1;
    next_cycle();
    check_outs("idle_passthrough", PASS);

    // Load x5 then add x6,x5,x1: one stall cycle, then pass-through.
    next_cycle();
    drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0);
    check_outs("lu_rs1_stall", STALL);
    next_cycle();
    drive(1'b0, 5'd6, 5'd5, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0);
    check_outs("lu_rs1_after", PASS);

    // Load x0: no stall even though rs1 matches.
    next_cycle();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0);
    check_outs("lu_x0_nostall", PASS);
    // rs2 matches but is not read: no stall.
    next_cycle();
    drive(1'b1, 5'd5, 5'd1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    check_outs("lu_rs2_unused", PASS);
    // rs2 matches and is read: stall.
    next_cycle();
    drive(1'b1, 5'd5, 5'd1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    check_outs("lu_rs2_stall", STALL);

    // Single multiply: hold t, t+1 (branch and load-use ignored), done t+2, pass t+3.
    next_cycle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    check_outs("mul_hold0_branch_ignored", HOLD);
    next_cycle();
    drive(1'b1, 5'd7, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
    check_outs("mul_hold1_lu_ignored", HOLD);
    next_cycle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    check_outs("mul_done", DONEP);
    next_cycle();
    idle_inputs();
    check_outs("mul_after", PASS);

    // Taken branch with a simultaneous load-use condition: flush wins.
    next_cycle();
    drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    check_outs("branch_over_lu", FLUSH);
    next_cycle();
    idle_inputs();
    check_outs("branch_after", PASS);

    // Counters after 2 load-use stalls, one 2-hold multiply, 1 flush.
    next_cycle();
`ifdef HAZ_PERF_CNT_EN
    check_cnt("cnt_load_use", cnt_load_use, 32'd2);
    check_cnt("cnt_mult_stall", cnt_mult_stall, 32'd2);
    check_cnt("cnt_flush", cnt_flush, 32'd1);
`else
    check_cnt("cnt_load_use_tied", cnt_load_use, '0);
    check_cnt("cnt_mult_stall_tied", cnt_mult_stall, '0);
    check_cnt("cnt_flush_tied", cnt_flush, '0);
`endif

    // Back-to-back multiplies: hold,hold,done,hold,hold,done,pass.
    next_cycle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    check_outs("b2b_hold_a0", HOLD);
    next_cycle();
    check_outs("b2b_hold_a1", HOLD);
    next_cycle();
    check_outs("b2b_done_a", DONEP);
    next_cycle();
    check_outs("b2b_hold_b0", HOLD);
    next_cycle();
    check_outs("b2b_hold_b1", HOLD);
    next_cycle();
    check_outs("b2b_done_b", DONEP);
    next_cycle();
    idle_inputs();
    check_outs("b2b_after", PASS);

    // Reset in the second hold cycle of a multiply aborts it without a done pulse.
    next_cycle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    check_outs("abort_hold0", HOLD);
    next_cycle();
    arst_n = 1'b0;
    check_outs("abort_reset_passthrough", PASS);
    check_cnt("abort_cnt_ms_cleared", cnt_mult_stall, '0);
    next_cycle();
    idle_inputs();
    arst_n = 1'b1;
    check_outs("abort_release", PASS);
    next_cycle();
    check_outs("abort_no_done", PASS);
    next_cycle();
    check_outs("abort_idle", PASS);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
